// File: rtl/hash_ctrl_pkg.sv
// Shared types and widths for the shared hash-core front end.
package hash_ctrl_pkg;

    localparam int unsigned DIGEST_W = 32;
    localparam int unsigned BYTE_W   = 8;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        FEED,
        WAIT_CORE,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: a lone request always wins, a tie goes to the favoured side.
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       favour,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = '0;
        if (req == 2'b11) begin
            gnt = favour ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/hash_share_ctrl.sv
// Shares one byte-serial hash core between two requesters, one whole message at a time.
module hash_share_ctrl
    import hash_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned LEN_W          = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              req_start,
    input  logic [2*LEN_W-1:0]      req_len,
    input  logic [1:0]              req_valid,
    input  logic [2*BYTE_W-1:0]     req_byte,
    output logic [1:0]              req_ready,
    output logic [1:0]              req_gnt,
    output logic [1:0]              req_done,
    output logic [2*DIGEST_W-1:0]   req_digest,
    output logic [1:0]              req_err,
    output logic                    hash_M_valid,
    output logic [BYTE_W-1:0]       hash_message,
    output logic [LEN_W-1:0]        hash_counter,
    input  logic [DIGEST_W-1:0]     hash_digest_out,
    input  logic                    hash_ready,
    output logic                    busy
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t             state;
    logic               favour;
    logic               owner;
    logic [LEN_W-1:0]   sent_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [1:0]         arb_gnt;
    logic [1:0]         owner_mask;
    logic [LEN_W-1:0]   win_len;
    logic [BYTE_W-1:0]  owner_byte;

    rr_arbiter_2 u_arb (
        .req    (req_start),
        .favour (favour),
        .gnt    (arb_gnt)
    );

    assign owner_mask = owner ? 2'b10 : 2'b01;
    assign win_len    = arb_gnt[1] ? req_len[2*LEN_W-1:LEN_W] : req_len[LEN_W-1:0];
    assign owner_byte = owner ? req_byte[2*BYTE_W-1:BYTE_W] : req_byte[BYTE_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            favour       <= 1'b0;
            owner        <= 1'b0;
            sent_cnt     <= '0;
            tmo_cnt      <= '0;
            req_ready    <= '0;
            req_gnt      <= '0;
            req_done     <= '0;
            req_err      <= '0;
            req_digest   <= '0;
            hash_M_valid <= 1'b0;
            hash_message <= '0;
            hash_counter <= '0;
            busy         <= 1'b0;
        end else begin
            hash_M_valid <= 1'b0;
            req_done     <= '0;
            req_err      <= '0;
            case (state)
                IDLE: begin
                    if (|req_start) begin
                        owner        <= arb_gnt[1];
                        favour       <= ~arb_gnt[1];
                        req_gnt      <= arb_gnt;
                        hash_counter <= win_len;
                        sent_cnt     <= '0;
                        busy         <= 1'b1;
                        state        <= GRANT;
                    end
                end
                GRANT: begin
                    // Zero-length messages still need one strobe so the core emits its digest.
                    if (hash_counter == '0) begin
                        hash_M_valid <= 1'b1;
                        hash_message <= '0;
                        tmo_cnt      <= '0;
                        state        <= WAIT_CORE;
                    end else begin
                        req_ready <= owner_mask;
                        state     <= FEED;
                    end
                end
                FEED: begin
                    if (|(req_valid & req_ready)) begin
                        hash_message <= owner_byte;
                        hash_M_valid <= 1'b1;
                        sent_cnt     <= sent_cnt + 1'b1;
                        req_ready    <= '0;
                        tmo_cnt      <= '0;
                        state        <= WAIT_CORE;
                    end
                end
                WAIT_CORE: begin
                    if (hash_ready) begin
                        if (sent_cnt == hash_counter) begin
                            if (owner) begin
                                req_digest[2*DIGEST_W-1:DIGEST_W] <= hash_digest_out;
                            end else begin
                                req_digest[DIGEST_W-1:0] <= hash_digest_out;
                            end
                            req_done <= owner_mask;
                            req_gnt  <= '0;
                            state    <= DONE;
                        end else begin
                            req_ready <= owner_mask;
                            state     <= FEED;
                        end
                    end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        // Error pulse lands exactly TIMEOUT_CYCLES after the strobe.
                        req_err <= owner_mask;
                        req_gnt <= '0;
                        state   <= ERR;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                DONE, ERR: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/hash_share_ctrl.md
HASH_SHARE_CTRL -- requirements
Module: hash_share_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, giving the maximum cycles to wait for hash_ready per core transfer.
REQ-002 SHALL have parameter LEN_W, default 64, giving the message-length width; it matches the hash core counter width.
REQ-003 clk  input  1  sole clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_start  input  2  level request per requester, held until that requester's done or err.
REQ-006 req_len  input  2*LEN_W  message length per requester; slice i belongs to requester i.
REQ-007 req_valid  input  2  byte-valid per requester.
REQ-008 req_byte  input  16  byte per requester; slice i belongs to requester i.
REQ-009 req_ready  output  2  byte accepted when req_valid[i] and req_ready[i] are both high.
REQ-010 req_gnt  output  2  one-hot grant; all zero when idle.
REQ-011 req_done  output  2  one-cycle pulse; req_digest slice is valid from this cycle.
REQ-012 req_digest  output  64  32-bit digest per requester, held until that requester's next done.
REQ-013 req_err  output  2  one-cycle timeout pulse.
REQ-014 hash_M_valid  output  1  one-cycle transfer strobe to the hash core.
REQ-015 hash_message  output  8  byte to the hash core.
REQ-016 hash_counter  output  LEN_W  total message length, held constant for the whole message.
REQ-017 hash_digest_out  input  32  digest from the hash core.
REQ-018 hash_ready  input  1  core handshake: transfer absorbed, and digest valid after the final transfer.
REQ-019 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-020 FSM states SHALL be IDLE, GRANT, FEED, WAIT_CORE, DONE and ERR.
REQ-021 In IDLE, when any req_start bit is high, the block SHALL register the round-robin winner, assert req_gnt the next cycle, latch req_len into hash_counter, and enter GRANT.
REQ-022 Round-robin SHALL favour the requester not served last. After reset the favoured requester is 0. With a single request, that request wins.
REQ-023 GRANT with length 0 SHALL pulse hash_M_valid with hash_counter=0 and enter WAIT_CORE (empty-message path).
REQ-024 GRANT with length nonzero SHALL enter FEED.
REQ-025 FEED SHALL assert req_ready for the granted requester only.
REQ-026 When a byte is accepted in FEED, the block SHALL drive that byte on hash_message with hash_M_valid high on the next cycle, increment the sent count, and enter WAIT_CORE; req_ready is low in that cycle.
REQ-027 WAIT_CORE with hash_ready high and sent count < length SHALL return to FEED.
REQ-028 WAIT_CORE with hash_ready high and sent count = length SHALL capture hash_digest_out and enter DONE.
REQ-029 DONE SHALL pulse req_done for the granted requester with the digest slice updated in the same cycle, drop req_gnt, and return to IDLE.
REQ-030 A timeout counter SHALL clear on entry to WAIT_CORE. When it reaches TIMEOUT_CYCLES without hash_ready, the block SHALL enter ERR.
REQ-031 ERR SHALL pulse req_err for the granted requester, drop req_gnt, and return to IDLE; req_digest is left unchanged.
REQ-032 hash_ready outside WAIT_CORE SHALL be ignored.
REQ-033 Deassertion of req_start by the granted requester mid-message SHALL be ignored; the message completes. Requests from the non-granted requester stay pending.
REQ-034 Minimum spacing between core strobes SHALL be 2 cycles. At most one hash_M_valid SHALL be issued per hash_ready.
REQ-035 The sent count and length compare SHALL be LEN_W bits wide; length 2^LEN_W-1 SHALL complete without wrap.

Reset
REQ-036 rst high SHALL force, on the next clock: state IDLE; req_ready, req_gnt, req_done and req_err all 0; req_digest 0; hash_M_valid 0; hash_message 0; hash_counter 0; busy 0; favoured requester 0; sent count and timeout counter 0.
REQ-037 Reset mid-message SHALL abandon the message without any done or err pulse.

Structure
REQ-038 Package hash_ctrl_pkg SHALL hold the FSM state enum, the digest width (32) and the byte width (8).
REQ-039 The round-robin grant logic SHALL be a sub-module rr_arbiter_2: 2 requests in, a favour pointer, and a one-hot grant out.

Verification
REQ-040 Empty message: req0 with len 0, real full_hash_des_box attached -> req_done[0] pulses and req_digest[31:0] = 32'h83656fd2.
REQ-041 Single byte: req1 sends "A" with len 1 -> req_done[1] pulses and req_digest[63:32] equals the digest obtained by driving the core directly with the same stimulus.
REQ-042 Simultaneous request: req_start=2'b11 on the first cycle after reset, each with len 1 -> req0 served fully, then req1; no overlap in hash_M_valid.
REQ-043 Fairness: req0 raises start again immediately after its done while req1 is pending -> req1 is granted next.
REQ-044 Timeout: core stub never asserts hash_ready, TIMEOUT_CYCLES=16, len 3 -> req_err pulses 16 cycles after the first hash_M_valid; no req_done; busy returns to 0.
REQ-045 Reset mid-message: rst asserted after 2 of 5 bytes -> all outputs 0 on the next cycle, no done or err pulse, and a fresh request then completes normally.
